pat_scan_ctrl: RTL and testbench
================================

# pat_scan_ctrl

Run controller for the serial pattern-detection datapath. It latches a run configuration (pattern, length, overlap mode, target hit count) on a start request and feeds a qualified serial bit stream through a shift-register matcher. It counts matches and reports completion, so a host can reuse one detector for different sequences (1101, 1011, …) instead of a hard-coded FSM per pattern.

## Interface
- PAT_W, 8, maximum pattern length in bits
- CNT_W, 8, width of match counter and target
- LEN_W, $clog2(PAT_W)+1, width of cfg_len (derived, not overridable)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- abort  in  1  terminate run, sampled in SCAN only
- cfg_pat  in  PAT_W  pattern; bit [cfg_len-1] is first bit expected, bit 0 last
- cfg_len  in  LEN_W  pattern length, legal 1..PAT_W
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  in  CNT_W  hits required to finish, legal ≥1
- bit_in  in  1  serial data
- bit_vld  in  1  bit_in qualifier
- busy  out  1  high in SCAN
- hit  out  1  one-cycle pulse per match
- match_cnt  out  CNT_W  matches in current/last run
- done  out  1  one-cycle pulse, target reached
- err  out  1  one-cycle pulse, start rejected for illegal config

## Operation
- States: IDLE, SCAN, DONE. Reset → IDLE; busy, hit, done, err = 0, match_cnt = 0, history/fill = 0.
- IDLE, start=1:
  - If cfg_len==0, cfg_len>PAT_W, or cfg_target==0: err=1 next cycle, stay IDLE, match_cnt unchanged.
  - Otherwise latch all cfg_* into internal registers, clear history, fill, and match_cnt, then → SCAN.
- cfg_* changes after latch have no effect until the next start.
- SCAN, bit_vld=1, abort=0:
  - history ← {history[PAT_W-2:0], bit_in}; fill ← min(fill+1, PAT_W).
  - Match when fill_new ≥ len and history_new[len-1:0] == pat[len-1:0].
- On match: hit=1, match_cnt+1.
  - Non-overlap: fill ← 0, so the matched bits are not reused.
  - Overlap: fill unchanged.
  - If match_cnt+1 == target → DONE.
- SCAN, abort=1: → IDLE at that edge. The bit presented in that cycle is discarded, no hit, no done, match_cnt holds.
- SCAN, bit_vld=0: no change. start is ignored in SCAN and DONE.
- DONE: done=1 for its single cycle, → IDLE unconditionally. bit_vld is ignored.
- match_cnt holds after DONE or abort until the next accepted start.
- Width: match_cnt cannot wrap; a run ends at the target, and target ≤ 2^CNT_W−1.

## Timing
- All outputs registered; no combinational input→output path.
- Start accepted at edge k: busy=1 from k. First bit sampled at edge k+1.
- A bit completing a match, sampled at edge m: hit=1 and match_cnt updated in cycle m..m+1. A bit at edge m+1 can match again (overlap, len=1).
- Final match at edge m: state DONE from m, done=1 and busy=0 in cycle m..m+1, IDLE from m+1. Earliest next start is sampled at edge m+2.
- Rejected start at edge k: err=1 in cycle k..k+1.
- rst low mid-run: immediate return to IDLE with reset values; no done pulse.

## Structure
- Package pat_scan_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - default PAT_W and CNT_W;
  - LEN_W derivation;
  - a config struct type (pat, len, ovl, target).
- Sub-module pat_shift_match holds history, fill, and the length-masked compare. Inputs: shift, clear, bit, latched pat/len. Output: match (combinational).
- pat_scan_ctrl holds the FSM, config latch, counter, and output registers.

## Test plan
- pat=4'b1101, len=4, ovl=1, target=2; stream 1,1,0,1,1,0,1 on consecutive cycles → hit after bits 4 and 7, match_cnt=2, done in the cycle after bit 7.
- Same stream, ovl=0, target=2 → single hit after bit 4, match_cnt=1, busy stays 1. Then abort → IDLE, no done, match_cnt=1.
- len=0, or len=9 with PAT_W=8, or target=0 with start → err pulse, busy=0, match_cnt unchanged.
- len=1, pat=1, ovl=1, target=3; stream 1,1,1 with bit_vld gaps between bits → hit on each valid bit only, done after the third.
- Assert rst low while match_cnt=1 mid-SCAN → all outputs 0 immediately. Release, start with same config → fresh count from 0.
- In the DONE cycle drive start=1 and bit_vld=1 → both ignored; start applied in the following cycle is accepted.

Source files
------------

// File: rtl/pat_scan_pkg.sv
// Shared types and defaults for the serial pattern-scan run controller.
// Holds no logic: the FSM state set, default widths and the latched run configuration layout.
package pat_scan_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = $clog2(PAT_W_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [PAT_W_DEF-1:0] pat;
    logic [LEN_W_DEF-1:0] len;
    logic                 ovl;
    logic [CNT_W_DEF-1:0] target;
  } cfg_t;

  function automatic int len_width(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/pat_shift_match.sv
// Shift-register matcher: history and fill registers with a length-masked compare.
// match_o is combinational from the bit being shifted in this cycle; no backpressure.
module pat_shift_match
  import pat_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic             bit_i,
  input  logic             ovl_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             match_o
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] mask;

  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], bit_i};
    fill_d = (fill_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill_q + 1'b1;
    mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_i));
    end
  end

  assign match_o = shift_i && (fill_d >= len_i) && ((hist_d & mask) == (pat_i & mask));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_d;
      // Non-overlapping runs restart the fill so matched bits cannot seed the next hit.
      fill_q <= (match_o && !ovl_i) ? '0 : fill_d;
    end
  end

endmodule

// File: rtl/pat_scan_ctrl.sv
// Run controller: latches a config on start, scans qualified serial bits, counts hits to a target.
// All outputs registered, hit/done one cycle after the deciding edge; bit_vld gates progress, abort ends a run.
module pat_scan_ctrl
  import pat_scan_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] cfg_pat_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cfg_ovl_i,
  input  logic [CNT_W-1:0] cfg_target_i,
  input  logic             bit_in_i,
  input  logic             bit_vld_i,
  output logic             busy_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             done_o,
  output logic             err_o
);

  // The latched configuration uses the package layout, so widths must agree with it.
  if (PAT_W != PAT_W_DEF || CNT_W != CNT_W_DEF || PAT_W < 2) begin : g_width_chk
    $error("pat_scan_ctrl: PAT_W/CNT_W must match pat_scan_pkg defaults and PAT_W >= 2");
  end

  state_e           state_q;
  cfg_t             cfg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, hit_q, done_q, err_q;

  logic             cfg_ok;
  logic             accept;
  logic             shift;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;

  assign cfg_ok  = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(PAT_W)) && (cfg_target_i != '0);
  assign accept  = (state_q == IDLE) && start_i && cfg_ok;
  assign shift   = (state_q == SCAN) && bit_vld_i && !abort_i;
  assign cnt_inc = cnt_q + CNT_W'(1);

  pat_shift_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .shift_i (shift),
    .clear_i (accept),
    .bit_i   (bit_in_i),
    .ovl_i   (cfg_q.ovl),
    .pat_i   (cfg_q.pat),
    .len_i   (cfg_q.len),
    .match_o (match)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              cfg_q   <= '{pat: cfg_pat_i, len: cfg_len_i, ovl: cfg_ovl_i, target: cfg_target_i};
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= SCAN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Abort wins over a bit arriving in the same cycle; shift is already gated by it.
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (match) begin
            hit_q <= 1'b1;
            cnt_q <= cnt_inc;
            if (cnt_inc == cfg_q.target) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign hit_o       = hit_q;
  assign match_cnt_o = cnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pat_scan_ctrl.sv
// Bench for pat_scan_ctrl: directed vector table, hand-written corner sequences, then random
// traffic, all checked against a window-queue reference model of the run rules.
module tb_pat_scan_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_ovl = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             bit_in = 1'b0;
  logic             bit_vld = 1'b0;
  logic             busy, hit, done, err;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  pat_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_pat_i    (cfg_pat),
    .cfg_len_i    (cfg_len),
    .cfg_ovl_i    (cfg_ovl),
    .cfg_target_i (cfg_target),
    .bit_in_i     (bit_in),
    .bit_vld_i    (bit_vld),
    .busy_o       (busy),
    .hit_o        (hit),
    .match_cnt_o  (match_cnt),
    .done_o       (done),
    .err_o        (err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic [7:0] tgt;
  } cfg_s;

  // Reference model: bits seen since the run start (or the last non-overlap hit), newest last.
  int   m_st;   // 0 idle, 1 scanning, 2 finishing
  cfg_s m_cfg;
  bit   win[$];
  int   m_cnt;
  bit   m_hit, m_done, m_err;

  function automatic bit win_match();
    int n;
    int l;
    n = win.size();
    l = int'(m_cfg.len);
    if (n < l) return 1'b0;
    for (int i = 0; i < l; i++) begin
      if (win[n-l+i] != m_cfg.pat[l-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_hit = 0; m_done = 0; m_err = 0;
    win.delete();
    m_cfg = '{pat: 8'h0, len: 4'h0, ovl: 1'b0, tgt: 8'h0};
  endtask

  task automatic model_step(input bit st, input bit ab, input bit vld, input bit b, input cfg_s c);
    m_hit = 0; m_done = 0; m_err = 0;
    case (m_st)
      0: if (st) begin
        if (c.len == 0 || int'(c.len) > PAT_W || c.tgt == 0) m_err = 1;
        else begin
          m_cfg = c; m_cnt = 0; win.delete(); m_st = 1;
        end
      end
      1: if (ab) m_st = 0;
         else if (vld) begin
           win.push_back(b);
           if (win.size() > 64) void'(win.pop_front());
           if (win_match()) begin
             m_hit = 1;
             m_cnt++;
             if (!m_cfg.ovl) win.delete();
             if (m_cnt == int'(m_cfg.tgt)) begin m_done = 1; m_st = 2; end
           end
         end
      default: m_st = 0;
    endcase
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_busy"}, busy, (m_st == 1) ? 1 : 0);
    chk({tag, "_hit"},  hit,  m_hit);
    chk({tag, "_cnt"},  match_cnt, m_cnt);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_err"},  err,  m_err);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, compare 1 ns later.
  task automatic apply(input bit st, input bit ab, input bit vld, input bit b, input cfg_s c, input string tag);
    start = st; abort = ab; bit_vld = vld; bit_in = b;
    cfg_pat = c.pat; cfg_len = c.len; cfg_ovl = c.ovl; cfg_target = c.tgt;
    @(posedge clk);
    model_step(st, ab, vld, b, c);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    bit st, ab, vld, b;
    int c;
    bit eb, eh;
    int ec;
    bit ed, ee;
  } vec_t;

  function automatic vec_t mkv(input bit st, input bit ab, input bit vld, input bit b, input int c,
                               input bit eb, input bit eh, input int ec, input bit ed, input bit ee);
    vec_t v;
    v.st = st; v.ab = ab; v.vld = vld; v.b = b; v.c = c;
    v.eb = eb; v.eh = eh; v.ec = ec; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  cfg_s cfgs[8];
  vec_t tbl[$];

  initial begin
    cfgs[0] = '{pat: 8'hFF, len: 4'd2, ovl: 1'b0, tgt: 8'd1};  // noise on cfg while not starting
    cfgs[1] = '{pat: 8'h0D, len: 4'd4, ovl: 1'b1, tgt: 8'd2};
    cfgs[2] = '{pat: 8'h0D, len: 4'd4, ovl: 1'b0, tgt: 8'd2};
    cfgs[3] = '{pat: 8'h0D, len: 4'd0, ovl: 1'b1, tgt: 8'd2};
    cfgs[4] = '{pat: 8'h0D, len: 4'd9, ovl: 1'b1, tgt: 8'd2};
    cfgs[5] = '{pat: 8'h0D, len: 4'd4, ovl: 1'b1, tgt: 8'd0};
    cfgs[6] = '{pat: 8'h01, len: 4'd1, ovl: 1'b1, tgt: 8'd3};
    cfgs[7] = '{pat: 8'h01, len: 4'd1, ovl: 1'b1, tgt: 8'd1};

    // Overlapping 1101 over 1101101: hits after bits 4 and 7, done with the second.
    tbl.push_back(mkv(1,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,0,0, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,1,1,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,1,0,0));
    tbl.push_back(mkv(0,0,1,0,0, 1,0,1,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 0,1,2,1,0));
    tbl.push_back(mkv(0,0,0,0,0, 0,0,2,0,0));
    // Non-overlapping: only one hit, then abort with a bit present.
    tbl.push_back(mkv(1,0,0,0,2, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,0,0, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,1,1,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,1,0,0));
    tbl.push_back(mkv(0,0,1,0,0, 1,0,1,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,0,1,0,0));
    tbl.push_back(mkv(0,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(mkv(0,0,0,0,0, 0,0,1,0,0));
    // Illegal configs: len 0, len 9, target 0.
    tbl.push_back(mkv(1,0,0,0,3, 0,0,1,0,1));
    tbl.push_back(mkv(1,0,0,0,4, 0,0,1,0,1));
    tbl.push_back(mkv(1,0,0,0,5, 0,0,1,0,1));
    tbl.push_back(mkv(0,0,0,0,0, 0,0,1,0,0));
    // len=1 with valid gaps.
    tbl.push_back(mkv(1,0,0,0,6, 1,0,0,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,1,1,0,0));
    tbl.push_back(mkv(0,0,0,1,0, 1,0,1,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 1,1,2,0,0));
    tbl.push_back(mkv(0,0,0,0,0, 1,0,2,0,0));
    tbl.push_back(mkv(0,0,1,0,0, 1,0,2,0,0));
    tbl.push_back(mkv(0,0,1,1,0, 0,1,3,1,0));
    tbl.push_back(mkv(0,0,0,0,0, 0,0,3,0,0));

    // Reset values.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("tbl%0d", i);
      apply(tbl[i].st, tbl[i].ab, tbl[i].vld, tbl[i].b, cfgs[tbl[i].c], t);
      chk({t, "_exp_busy"}, busy, tbl[i].eb);
      chk({t, "_exp_hit"},  hit,  tbl[i].eh);
      chk({t, "_exp_cnt"},  match_cnt, tbl[i].ec);
      chk({t, "_exp_done"}, done, tbl[i].ed);
      chk({t, "_exp_err"},  err,  tbl[i].ee);
    end

    // start and a matching bit in the DONE cycle are both ignored; the next start is taken.
    apply(1, 0, 0, 0, cfgs[7], "dn_start");
    apply(0, 0, 1, 1, cfgs[0], "dn_bit");
    chk("dn_done_pulse", done, 1);
    chk("dn_busy_low", busy, 0);
    apply(1, 0, 1, 1, cfgs[7], "dn_ignored");
    chk("dn_ign_busy", busy, 0);
    chk("dn_ign_hit", hit, 0);
    chk("dn_ign_cnt", match_cnt, 1);
    apply(1, 0, 0, 0, cfgs[1], "dn_restart");
    chk("dn_restart_busy", busy, 1);
    chk("dn_restart_cnt", match_cnt, 0);
    apply(0, 1, 0, 0, cfgs[0], "dn_abort");

    // Asynchronous reset mid-run with match_cnt=1 and hit still high.
    apply(1, 0, 0, 0, cfgs[1], "ar_start");
    apply(0, 0, 1, 1, cfgs[0], "ar_b1");
    apply(0, 0, 1, 1, cfgs[0], "ar_b2");
    apply(0, 0, 1, 0, cfgs[0], "ar_b3");
    apply(0, 0, 1, 1, cfgs[0], "ar_b4");
    chk("ar_pre_cnt", match_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_hit", hit, 0);
    chk("ar_cnt", match_cnt, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    model_reset();
    start = 0; abort = 0; bit_vld = 0; bit_in = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 0, 0, cfgs[1], "ar_restart");
    chk("ar_restart_cnt", match_cnt, 0);
    apply(0, 0, 1, 1, cfgs[0], "ar_r1");
    apply(0, 0, 1, 1, cfgs[0], "ar_r2");
    apply(0, 0, 1, 0, cfgs[0], "ar_r3");
    apply(0, 0, 1, 1, cfgs[0], "ar_r4");
    chk("ar_fresh_cnt", match_cnt, 1);
    apply(0, 1, 0, 0, cfgs[0], "ar_abort");

    // Random traffic, biased to short patterns so runs complete.
    for (int n = 0; n < 3000; n++) begin
      cfg_s c;
      bit   st, ab, vld, b;
      c.pat = 8'($urandom);
      c.len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 3));
      c.ovl = 1'($urandom_range(0, 1));
      c.tgt = 8'($urandom_range(0, 4));
      st  = ($urandom_range(0, 7) == 0);
      ab  = ($urandom_range(0, 39) == 0);
      vld = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      apply(st, ab, vld, b, c, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
